// File: rtl/csr_unit.sv
// Control/status register file for the Riscv151 writeback stage: CSRRW/RS/RC,
// 64-bit cycle/instret counters, mscratch and a tohost FIFO drained by the testbench.
module csr_unit #(
    parameter int XLEN         = 32,
    parameter int TOHOST_DEPTH = 4,
    parameter int CNT_WIDTH    = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_csr_en,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    input  logic            i_retire,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_busy,
    output logic            o_illegal,
    output logic            o_tohost_valid,
    output logic [XLEN-1:0] o_tohost_data,
    input  logic            i_tohost_ready,
    output logic [XLEN-1:0] o_tohost_last
);

    localparam int PTR_W = $clog2(TOHOST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    function automatic logic [XLEN-1:0] csr_update(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_v,
        input logic [XLEN-1:0] wdata_v
    );
        logic [XLEN-1:0] res;
        case (op)
            OP_RW:   res = wdata_v;
            OP_RS:   res = old_v | wdata_v;
            OP_RC:   res = old_v & ~wdata_v;
            default: res = old_v;
        endcase
        return res;
    endfunction

    logic [CNT_WIDTH-1:0] r_cycle;
    logic [CNT_WIDTH-1:0] r_instret;
    logic [XLEN-1:0]      r_mscratch;
    logic [XLEN-1:0]      r_tohost_last;
    logic [XLEN-1:0]      r_mem [TOHOST_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [63:0]     w_cycle64;
    logic [63:0]     w_instret64;
    logic [XLEN-1:0] w_old;
    logic            w_mapped;
    logic            w_ro;
    logic            w_active;
    logic            w_ro_violation;
    logic            w_illegal;
    logic            w_full;
    logic            w_busy;
    logic            w_commit;
    logic [XLEN-1:0] w_new;
    logic            w_push;
    logic            w_scratch_we;
    logic            w_pop;
    logic            w_retire_inc;

    // Counters are presented as 64 bits so the high-half CSRs zero-extend narrow counters.
    assign w_cycle64   = 64'(r_cycle);
    assign w_instret64 = 64'(r_instret);

    // Address decode: current value of the addressed CSR and its access class.
    always_comb begin
        w_old    = {XLEN{1'b0}};
        w_mapped = 1'b0;
        w_ro     = 1'b0;
        case (i_csr_addr)
            ADDR_TOHOST: begin
                w_mapped = 1'b1;
                w_old    = r_tohost_last;
            end
            ADDR_MSCRATCH: begin
                w_mapped = 1'b1;
                w_old    = r_mscratch;
            end
            ADDR_CYCLE: begin
                w_mapped = 1'b1;
                w_ro     = 1'b1;
                w_old    = XLEN'(w_cycle64[31:0]);
            end
            ADDR_CYCLEH: begin
                w_mapped = 1'b1;
                w_ro     = 1'b1;
                w_old    = XLEN'(w_cycle64[63:32]);
            end
            ADDR_INSTRET: begin
                w_mapped = 1'b1;
                w_ro     = 1'b1;
                w_old    = XLEN'(w_instret64[31:0]);
            end
            ADDR_INSTRETH: begin
                w_mapped = 1'b1;
                w_ro     = 1'b1;
                w_old    = XLEN'(w_instret64[63:32]);
            end
            default: begin
                w_mapped = 1'b0;
                w_ro     = 1'b0;
                w_old    = {XLEN{1'b0}};
            end
        endcase
    end

    assign w_active       = i_csr_en && (i_csr_op != OP_NONE);
    // Set/clear with a zero mask is a pure read and therefore legal on counters.
    assign w_ro_violation = w_ro && ((i_csr_op == OP_RW) || (i_csr_wdata != {XLEN{1'b0}}));
    assign w_illegal      = w_active && (!w_mapped || w_ro_violation);

    // Busy looks only at the registered count so tohost_ready never reaches the stall path.
    assign w_full   = (r_count == CNT_W'(TOHOST_DEPTH));
    assign w_busy   = w_active && (i_csr_addr == ADDR_TOHOST) && w_full;
    assign w_commit = w_active && !i_stall && !w_busy && !w_illegal;
    assign w_new    = csr_update(i_csr_op, w_old, i_csr_wdata);

    assign w_push       = w_commit && (i_csr_addr == ADDR_TOHOST);
    assign w_scratch_we = w_commit && (i_csr_addr == ADDR_MSCRATCH);
    assign w_pop        = (r_count != {CNT_W{1'b0}}) && i_tohost_ready;
    assign w_retire_inc = i_retire && !i_stall && !w_busy;

    // Architectural state, counters and FIFO bookkeeping; reset beats every update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle       <= {CNT_WIDTH{1'b0}};
            r_instret     <= {CNT_WIDTH{1'b0}};
            r_mscratch    <= {XLEN{1'b0}};
            r_tohost_last <= {XLEN{1'b0}};
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
        end else begin
            r_cycle <= r_cycle + CNT_WIDTH'(1);
            if (w_retire_inc) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
            if (w_scratch_we) begin
                r_mscratch <= w_new;
            end
            if (w_push) begin
                r_tohost_last <= w_new;
                r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; stale entries after reset are unreachable because the pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    assign o_csr_rdata    = w_old;
    assign o_illegal      = w_illegal;
    assign o_csr_busy     = w_busy;
    assign o_tohost_valid = (r_count != {CNT_W{1'b0}});
    assign o_tohost_data  = r_mem[r_rd_ptr];
    assign o_tohost_last  = r_tohost_last;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, FIFO corner sequences,
// randomized traffic against a queue-based model, and a 33-bit counter wrap check.
module tb_csr_unit;

    localparam int DEPTH = 4;
    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    typedef struct {
        bit        rst;
        bit        stall;
        bit        en;
        bit [1:0]  op;
        bit [11:0] addr;
        bit [31:0] wdata;
        bit        retire;
        bit        ready;
        bit [31:0] e_rdata;
        bit        e_ill;
        bit        e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, csr_en, retire, tohost_ready;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata, tohost_data, tohost_last;
    logic        csr_busy, illegal, tohost_valid;

    logic [11:0] d33_addr;
    logic [31:0] d33_rdata, d33_tdata, d33_tlast;
    logic        d33_busy, d33_ill, d33_tvalid;

    int n_cmp = 0;
    int n_fail = 0;

    longint unsigned m_cycle, m_instret;
    logic [31:0]     m_scratch, m_last;
    logic [31:0]     m_fifo[$];
    logic [31:0]     drained[$];
    vec_t            tbl[$];

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .TOHOST_DEPTH(DEPTH), .CNT_WIDTH(64)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_csr_en(csr_en),
        .i_csr_op(csr_op), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .i_retire(retire), .o_csr_rdata(csr_rdata), .o_csr_busy(csr_busy),
        .o_illegal(illegal), .o_tohost_valid(tohost_valid),
        .o_tohost_data(tohost_data), .i_tohost_ready(tohost_ready),
        .o_tohost_last(tohost_last)
    );

    csr_unit #(.XLEN(32), .TOHOST_DEPTH(DEPTH), .CNT_WIDTH(33)) dut33 (
        .i_clk(clk), .i_reset(reset), .i_stall(1'b0), .i_csr_en(1'b1),
        .i_csr_op(RS), .i_csr_addr(d33_addr), .i_csr_wdata(32'h0),
        .i_retire(1'b0), .o_csr_rdata(d33_rdata), .o_csr_busy(d33_busy),
        .o_illegal(d33_ill), .o_tohost_valid(d33_tvalid),
        .o_tohost_data(d33_tdata), .i_tohost_ready(1'b0),
        .o_tohost_last(d33_tlast)
    );

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, bit stl, bit en, bit [1:0] op, bit [11:0] addr,
                                bit [31:0] wd, bit ret, bit rdy,
                                bit [31:0] er, bit ei, bit eb);
        vec_t v;
        v.rst = rst; v.stall = stl; v.en = en; v.op = op; v.addr = addr;
        v.wdata = wd; v.retire = ret; v.ready = rdy;
        v.e_rdata = er; v.e_ill = ei; v.e_busy = eb;
        return v;
    endfunction

    // Reference view of the CSR map.
    function automatic void m_decode(input logic [11:0] a, output bit mapped,
                                     output bit ro, output logic [31:0] old);
        mapped = 1'b1;
        ro     = 1'b1;
        case (a)
            12'h51E: begin ro = 1'b0; old = m_last; end
            12'h340: begin ro = 1'b0; old = m_scratch; end
            12'hC00: old = m_cycle[31:0];
            12'hC80: old = m_cycle[63:32];
            12'hC02: old = m_instret[31:0];
            12'hC82: old = m_instret[63:32];
            default: begin mapped = 1'b0; ro = 1'b0; old = 32'h0; end
        endcase
    endfunction

    task automatic model_eval(output bit act, output bit ill, output bit bsy,
                              output bit mapped, output logic [31:0] old);
        bit ro;
        m_decode(csr_addr, mapped, ro, old);
        act = csr_en && (csr_op != 2'b00);
        ill = act && (!mapped || (ro && (csr_op == RW || csr_wdata != 32'h0)));
        bsy = act && (csr_addr == 12'h51E) && (m_fifo.size() == DEPTH);
    endtask

    task automatic model_check();
        bit act, ill, bsy, mapped;
        logic [31:0] old;
        model_eval(act, ill, bsy, mapped, old);
        cmp1("illegal", illegal, ill);
        cmp1("busy", csr_busy, bsy);
        if (act) cmp32("rdata", csr_rdata, mapped ? old : 32'h0);
        cmp1("tohost_valid", tohost_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) cmp32("tohost_data", tohost_data, m_fifo[0]);
        cmp32("tohost_last", tohost_last, m_last);
    endtask

    task automatic model_update();
        bit act, ill, bsy, mapped;
        logic [31:0] old, nv;
        model_eval(act, ill, bsy, mapped, old);
        if (reset) begin
            m_cycle = 0; m_instret = 0; m_scratch = 32'h0; m_last = 32'h0;
            m_fifo.delete();
        end else begin
            m_cycle++;
            if (retire && !stall && !bsy) m_instret++;
            if (m_fifo.size() != 0 && tohost_ready) void'(m_fifo.pop_front());
            nv = (csr_op == RW) ? csr_wdata : (csr_op == RS) ? (old | csr_wdata) : (old & ~csr_wdata);
            if (act && !stall && !bsy && !ill) begin
                if (csr_addr == 12'h51E) begin
                    m_fifo.push_back(nv);
                    m_last = nv;
                end else if (csr_addr == 12'h340) begin
                    m_scratch = nv;
                end
            end
        end
    endtask

    task automatic cycle_run(input vec_t v, input bit chk, input int idx);
        @(negedge clk);
        reset = v.rst; stall = v.stall; csr_en = v.en; csr_op = v.op;
        csr_addr = v.addr; csr_wdata = v.wdata; retire = v.retire; tohost_ready = v.ready;
        #1;
        model_check();
        if (chk) begin
            if (v.en && v.op != 2'b00) cmp32($sformatf("vec%0d rdata", idx), csr_rdata, v.e_rdata);
            cmp1($sformatf("vec%0d illegal", idx), illegal, v.e_ill);
            cmp1($sformatf("vec%0d busy", idx), csr_busy, v.e_busy);
        end
        if (tohost_valid && tohost_ready) drained.push_back(tohost_data);
        @(posedge clk);
        model_update();
    endtask

    task automatic check_drained(input string name, input logic [31:0] first, input int n);
        cmp32({name, " count"}, drained.size(), n);
        for (int i = 0; i < n && i < drained.size(); i++)
            cmp32($sformatf("%s[%0d]", name, i), drained[i], first + i);
        drained.delete();
    endtask

    initial begin
        int s1, s2, s3;
        logic [11:0] amap [8];
        vec_t rv;
        amap = '{12'h51E, 12'h340, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF, 12'h000};

        reset = 1'b1; stall = 1'b0; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0;
        csr_wdata = 32'h0; retire = 1'b0; tohost_ready = 1'b0; d33_addr = 12'hC00;
        repeat (2) @(posedge clk);
        m_cycle = 0; m_instret = 0; m_scratch = 32'h0; m_last = 32'h0;

        // Reset, idle, counter reads, mscratch RW/RS/RC, illegal accesses.
        tbl.push_back(mk(1, 0, 0, 2'b00, 12'h0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 2'b00, 12'h0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC00, 0, 0, 0, 32'd10, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC02, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC80, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RW, 12'h340, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h340, 32'h0000F000, 0, 0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 0, 1, RC, 12'h340, 32'h000000EF, 0, 0, 32'hDEADFEEF, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h340, 0, 0, 0, 32'hDEADFE00, 0, 0));
        tbl.push_back(mk(0, 0, 1, RW, 12'hC02, 32'd7, 0, 0, 32'd0, 1, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h7FF, 0, 0, 0, 32'd0, 1, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC02, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h340, 0, 0, 0, 32'hDEADFE00, 0, 0));
        tbl.push_back(mk(0, 1, 1, RS, 12'hC00, 0, 0, 0, 32'd21, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 12'h0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, RS, 12'hC02, 0, 1, 0, 32'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC02, 0, 0, 0, 32'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC82, 0, 0, 0, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC80, 32'd1, 0, 0, 32'd0, 1, 0));
        tbl.push_back(mk(0, 0, 1, RC, 12'hC00, 0, 0, 0, 32'd27, 0, 0));
        s1 = tbl.size();
        // Fill to full with ready low, hold the fifth write, then drain.
        for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 0, 1, RW, 12'h51E, k, 0, 0, k - 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 5, 0, 0, 32'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 5, 0, 0, 32'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 5, 0, 1, 32'd4, 0, 1));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 5, 0, 1, 32'd4, 0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 0, 2'b00, 12'h0, 0, 0, 1, 0, 0, 0));
        s2 = tbl.size();
        // Sustained push+pop: nine back-to-back writes wrap both pointers twice.
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 100 + i, 0, 1, (i == 0) ? 32'd5 : 99 + i, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 2'b00, 12'h0, 0, 0, 1, 0, 0, 0));
        s3 = tbl.size();
        // Reset with three entries pending, stall high and a simultaneous push and pop.
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 32'hA1, 0, 0, 32'd108, 0, 0));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 32'hA2, 0, 0, 32'hA1, 0, 0));
        tbl.push_back(mk(0, 0, 1, RW, 12'h51E, 32'hA3, 0, 0, 32'hA2, 0, 0));
        tbl.push_back(mk(1, 1, 1, RW, 12'h51E, 32'h77, 0, 1, 32'hA3, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC00, 0, 0, 1, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'hC02, 0, 0, 1, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h340, 0, 0, 1, 32'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, RS, 12'h7FF, 0, 0, 1, 32'd0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == s1 || i == s3) drained.delete();
            if (i == s2) check_drained("drain_full", 32'd1, 5);
            cycle_run(tbl[i], 1'b1, i);
            if (i == s3 - 1) check_drained("drain_b2b", 32'd100, 9);
        end
        cmp1("post_reset_valid", tohost_valid, 1'b0);
        cmp32("post_reset_last", tohost_last, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(399) == 0), ($urandom_range(4) == 0), ($urandom_range(4) != 0),
                    2'($urandom_range(3)), amap[$urandom_range(7)],
                    ($urandom_range(3) == 0) ? 32'h0 : $urandom, $urandom_range(1) == 1,
                    $urandom_range(1) == 1, 0, 0, 0);
            cycle_run(rv, 1'b0, i);
        end

        // 33-bit counter: preload just below 2^32+2 and check both halves, then the wrap.
        @(negedge clk);
        reset = 1'b0;
        force dut33.r_cycle = 33'h1_0000_0000;
        #1;
        release dut33.r_cycle;
        repeat (2) @(posedge clk);
        @(negedge clk);
        d33_addr = 12'hC00; #1;
        cmp32("cnt33 cycle", d33_rdata, 32'd2);
        d33_addr = 12'hC80; #1;
        cmp32("cnt33 cycleh", d33_rdata, 32'd1);
        force dut33.r_cycle = 33'h1_FFFF_FFFF;
        #1;
        release dut33.r_cycle;
        @(posedge clk);
        @(negedge clk);
        d33_addr = 12'hC00; #1;
        cmp32("cnt33 wrap lo", d33_rdata, 32'd0);
        d33_addr = 12'hC80; #1;
        cmp32("cnt33 wrap hi", d33_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised control/status register unit for the Riscv151 core, replacing the single `tohost` register with a small CSR file. It sits beside the writeback stage and executes CSRRW/CSRRS/CSRRC (and immediate forms) there. It adds 64-bit `cycle`/`instret` counters, an `mscratch` register and a `tohost` FIFO with a valid/ready drain to the testbench. It also provides a busy signal that the core ORs into its pipeline stall.

## Interface
- XLEN, 32: data width of CSR ports and registers
- TOHOST_DEPTH, 4: tohost FIFO entries; power of two, ≥2
- CNT_WIDTH, 64: width of cycle/instret counters; 33..64
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  global pipeline stall (cache stall from the core)
- csr_en  in  1  writeback-stage instruction is a CSR access
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1 value, or zero-extended zimm
- retire  in  1  an instruction retires in writeback this cycle
- csr_rdata  out  XLEN  old value of addressed CSR, for the rd writeback
- csr_busy  out  1  access cannot complete this cycle; core must stall
- illegal  out  1  current access is to an unmapped or read-only-violating CSR
- tohost_valid  out  1  FIFO head valid
- tohost_data  out  XLEN  FIFO head value
- tohost_ready  in  1  testbench consumes head
- tohost_last  out  XLEN  last value accepted into tohost (legacy `csr` output)

## Operation
- Address map:
  - 0x51E `tohost`: write-only push; reads return `tohost_last`.
  - 0x340 `mscratch`: RW.
  - 0xC00 `cycle` and 0xC80 `cycleh`: read-only low and high halves.
  - 0xC02 `instret` and 0xC82 `instreth`: read-only low and high halves.
  - High halves are zero-extended when CNT_WIDTH < 64.
- An access is active when csr_en=1 and csr_op≠00.
- An access commits at the clock edge when active && !stall && !csr_busy.
- New value per op:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
- `tohost` with RS/RC: the push value is the computed value, with old=`tohost_last`.
- Read-only counters:
  - RW, or RS/RC with wdata≠0, sets illegal=1 and has no state effect.
  - RS/RC with wdata=0 is a legal read.
- Unmapped address: illegal=1, csr_rdata=0, no state effect.
- illegal is combinational and valid whenever the access is active. The core traps or ignores it; this block only flags it.
- tohost FIFO:
  - Circular buffer with read/write pointers mod TOHOST_DEPTH and an occupancy count.
  - Committed tohost write pushes the value and updates `tohost_last`.
  - Pop occurs when tohost_valid && tohost_ready.
  - Push and pop in the same cycle leave the count unchanged. Both pointers advance and wrap independently.
- csr_busy = active && addr==0x51E && count==TOHOST_DEPTH, evaluated on the registered count. A same-cycle pop does not clear busy; the push is accepted the following cycle.
- cycle: increments every cycle reset is low, including stalled cycles. Wraps to 0 at 2^CNT_WIDTH.
- instret: increments when retire && !stall && !csr_busy. Wraps likewise.
- Reset clears all state:
  - counters, mscratch, tohost_last, FIFO pointers and count are 0;
  - tohost_valid=0, csr_busy=0, illegal=0.
- Reset mid-operation discards FIFO contents. Reset has priority over every simultaneous push, pop or write.

## Timing
- csr_rdata, illegal and csr_busy are combinational from registered state plus the csr_* inputs. No path from tohost_ready to csr_busy.
- csr_rdata returns the value before this cycle's update.
- Counter reads in cycle N return the count at the start of cycle N.
- Write to mscratch or tohost in cycle N is visible to a read in cycle N+1.
- Push at edge N: tohost_valid=1 and tohost_data valid from cycle N+1. No empty-FIFO bypass.
- Pop at edge N: next head, or valid=0 if empty, from cycle N+1.
- Full throughput: one push and one pop per cycle, sustained.
- Stall freezes all CSR commits and instret. It does not freeze cycle or the FIFO drain side.

## Test plan
- Reset, then 10 idle cycles:
  - cycle reads 10 via csrrs x,0xC00,x0;
  - instret 0, tohost_valid 0, tohost_last 0.
- csrrw mscratch with 0xDEADBEEF, then csrrs with 0x0000F000, then csrrc with 0x000000EF:
  - rdata sequence 0, 0xDEADBEEF, 0xDEADFEEF;
  - final value 0xDEADFE00.
- tohost_ready=0, 5 tohost writes 1..5 (TOHOST_DEPTH=4):
  - writes 1–4 accepted;
  - 5th holds csr_busy=1.
  - Raise ready: drain order 1,2,3,4, then 5, with busy deasserting the cycle after the first pop.
- ready=1, back-to-back tohost writes across 9 cycles: one pop per cycle, pointer wrap correct, data in order.
- csrrw to 0xC02 with wdata 7, and a read of 0x7FF:
  - illegal=1, no state change;
  - csrrs 0xC02 with x0 gives illegal=0.
- Set CNT_WIDTH=33 and run 2^32+3 cycles (or preload via force): cycleh=1, cycle=2.
- Reset asserted with 3 FIFO entries pending and stall=1: next cycle FIFO empty, all counters 0.
